// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the requester and the byte-wide register file.
interface apb_slave_regfile_if;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [7:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pready;
   logic       pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer with a byte-wide register file, fixed wait-state insertion,
// a read-only ID register at 8'hFF and error response for unmapped addresses.
//
// state  | meaning
// S_IDLE | no transfer in flight, pready high, waiting for a setup phase
// S_WAIT | access phase stalled, pready low, cnt counting down wait cycles
// S_DONE | completion cycle, pready high, write commits at the ending edge
module apb_slave_regfile #(
   parameter int         DEPTH       = 16,
   parameter int         WAIT_CYCLES = 1,
   parameter logic [7:0] ID_VALUE    = 8'hA5
) (
   input  logic               pclk,
   input  logic               prstn,
   apb_slave_regfile_if.slave apb
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);
   localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

   state_t        state;
   logic [2:0]    cnt;
   logic          pready_q;
   logic [7:0]    mem [DEPTH];
   logic [7:0]    prdata_c;
   logic [AW-1:0] idx;
   logic          in_range;
   logic          is_id;
   logic          setup;
   logic          wr_commit;

   // Address decode; idx is only meaningful while in_range is set.
   assign idx       = apb.paddr[AW-1:0];
   assign in_range  = {1'b0, apb.paddr} < DEPTH_LIM;
   assign is_id     = apb.paddr == 8'hFF;
   assign setup     = apb.psel & ~apb.penable;
   assign wr_commit = apb.psel & apb.penable & pready_q & apb.pwrite & in_range;

   // Transfer sequencing with registered pready.
   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         state    <= S_IDLE;
         cnt      <= '0;
         pready_q <= 1'b1;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (setup) begin
                  cnt <= WAIT_INIT;
                  if (WAIT_INIT != 3'd0) begin
                     state    <= S_WAIT;
                     pready_q <= 1'b0;
                  end else begin
                     state    <= S_DONE;
                     pready_q <= 1'b1;
                  end
               end else begin
                  state    <= S_IDLE;
                  pready_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (!apb.psel) begin
                  // Requester abandoned the transfer; nothing gets written.
                  state    <= S_IDLE;
                  cnt      <= '0;
                  pready_q <= 1'b1;
               end else begin
                  cnt <= cnt - 3'd1;
                  if (cnt == 3'd1) begin
                     state    <= S_DONE;
                     pready_q <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= S_IDLE;
               cnt      <= '0;
               pready_q <= 1'b1;
            end
         endcase
      end
   end

   // Register file storage; only mapped addresses are written.
   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_commit) begin
         mem[idx] <= apb.pwdata;
      end
   end

   // Read data mux; zero outside a read access so the bus stays quiet.
   always_comb begin
      prdata_c = 8'h00;
      if (apb.psel && apb.penable && !apb.pwrite) begin
         if (in_range) begin
            prdata_c = mem[idx];
         end else if (is_id) begin
            prdata_c = ID_VALUE;
         end
      end
   end

   assign apb.prdata  = prdata_c;
   assign apb.pready  = pready_q;
   assign apb.pslverr = apb.psel & apb.penable & pready_q & ~in_range & ~is_id;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: three instances with 1, 0 and 3 wait
// states share one clock and reset; a select steers the requester onto one.
module tb_apb_slave_regfile;

   typedef struct packed {
      logic [7:0] rd;
      logic       err;
      logic [7:0] waits;
   } exp_t;

   logic       pclk;
   logic       prstn;
   logic       m_psel;
   logic       m_penable;
   logic       m_pwrite;
   logic [7:0] m_paddr;
   logic [7:0] m_pwdata;
   int         sel;

   logic [7:0] o_prdata;
   logic       o_pready;
   logic       o_pslverr;

   int         errors;
   int         checks;
   exp_t       sb [$];
   logic [7:0] mdl [3][16];

   apb_slave_regfile_if bus0 ();
   apb_slave_regfile_if bus1 ();
   apb_slave_regfile_if bus2 ();

   apb_slave_regfile #(.WAIT_CYCLES(1)) dut0 (.pclk(pclk), .prstn(prstn), .apb(bus0));
   apb_slave_regfile #(.WAIT_CYCLES(0)) dut1 (.pclk(pclk), .prstn(prstn), .apb(bus1));
   apb_slave_regfile #(.WAIT_CYCLES(3)) dut2 (.pclk(pclk), .prstn(prstn), .apb(bus2));

   assign bus0.psel    = m_psel && (sel == 0);
   assign bus1.psel    = m_psel && (sel == 1);
   assign bus2.psel    = m_psel && (sel == 2);
   assign bus0.penable = m_penable;
   assign bus1.penable = m_penable;
   assign bus2.penable = m_penable;
   assign bus0.pwrite  = m_pwrite;
   assign bus1.pwrite  = m_pwrite;
   assign bus2.pwrite  = m_pwrite;
   assign bus0.paddr   = m_paddr;
   assign bus1.paddr   = m_paddr;
   assign bus2.paddr   = m_paddr;
   assign bus0.pwdata  = m_pwdata;
   assign bus1.pwdata  = m_pwdata;
   assign bus2.pwdata  = m_pwdata;

   always_comb begin
      o_prdata  = bus0.prdata;
      o_pready  = bus0.pready;
      o_pslverr = bus0.pslverr;
      if (sel == 1) begin
         o_prdata  = bus1.prdata;
         o_pready  = bus1.pready;
         o_pslverr = bus1.pslverr;
      end else if (sel == 2) begin
         o_prdata  = bus2.prdata;
         o_pready  = bus2.pready;
         o_pslverr = bus2.pslverr;
      end
   end

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   function automatic logic [7:0] wait_of(input int s);
      if (s == 1) return 8'd0;
      if (s == 2) return 8'd3;
      return 8'd1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int s = 0; s < 3; s++)
         for (int r = 0; r < 16; r++)
            mdl[s][r] = 8'h00;
   endtask

   // One complete transfer on the selected instance; leaves the bus in the
   // completion cycle so a following call runs back-to-back.
   task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d, input string tag);
      exp_t e;
      exp_t got;
      int   waits;
      bit   done;
      e.waits = wait_of(sel);
      e.err   = (a >= 8'd16) && (a != 8'hFF);
      if (wr)              e.rd = 8'h00;
      else if (a < 8'd16)  e.rd = mdl[sel][a[3:0]];
      else if (a == 8'hFF) e.rd = 8'hA5;
      else                 e.rd = 8'h00;
      sb.push_back(e);
      @(posedge pclk); #1;
      m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr; m_paddr = a; m_pwdata = d;
      @(posedge pclk); #1;
      m_penable = 1'b1;
      waits = 0;
      done  = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge pclk);
         if (o_pready) done = 1'b1;
         else begin
            waits++;
            @(posedge pclk); #1;
         end
      end
      got = sb.pop_front();
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".prdata"}, 32'(o_prdata), 32'(got.rd));
      chk({tag, ".pslverr"}, 32'(o_pslverr), 32'(got.err));
      chk({tag, ".waits"}, 32'(waits), 32'(got.waits));
      if (done && wr && a < 8'd16) mdl[sel][a[3:0]] = d;
   endtask

   task automatic idle(input int n);
      @(posedge pclk); #1;
      m_psel = 1'b0; m_penable = 1'b0;
      repeat (n) @(posedge pclk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      errors = 0; checks = 0;
      prstn = 1'b0; sel = 0;
      m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = 8'h00; m_pwdata = 8'h00;
      clear_model();
      repeat (2) @(posedge pclk);
      #1 prstn = 1'b1;
      @(negedge pclk);
      chk("rst.pready", 32'(o_pready), 32'd1);
      chk("rst.pslverr", 32'(o_pslverr), 32'd0);
      chk("rst.prdata", 32'(o_prdata), 32'h00);

      // One wait state: basic access, unmapped addresses, ID register.
      xfer(1'b0, 8'h03, 8'h00, "w1.rd3");
      xfer(1'b1, 8'h02, 8'h5C, "w1.wr2");
      xfer(1'b0, 8'h02, 8'h00, "w1.rd2");
      xfer(1'b1, 8'h00, 8'h4B, "w1.wr0");
      xfer(1'b1, 8'h10, 8'h77, "w1.wr_unmapped");
      xfer(1'b0, 8'h00, 8'h00, "w1.rd0_after_unmapped");
      xfer(1'b0, 8'h80, 8'h00, "w1.rd_unmapped");
      xfer(1'b0, 8'hFF, 8'h00, "w1.rd_id");
      xfer(1'b1, 8'hFF, 8'h00, "w1.wr_id");
      xfer(1'b0, 8'hFF, 8'h00, "w1.rd_id_again");
      idle(1);

      // Zero wait states, back-to-back transfers.
      sel = 1;
      xfer(1'b1, 8'h00, 8'h11, "w0.wr0");
      xfer(1'b1, 8'h0F, 8'h22, "w0.wr15");
      xfer(1'b0, 8'h00, 8'h00, "w0.rd0");
      xfer(1'b0, 8'h0F, 8'h00, "w0.rd15");
      idle(1);

      // Three wait states: normal access, then an abort mid-wait.
      sel = 2;
      xfer(1'b1, 8'h06, 8'hC3, "w3.wr6");
      xfer(1'b0, 8'h06, 8'h00, "w3.rd6");
      idle(1);
      @(posedge pclk); #1;
      m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1; m_paddr = 8'h04; m_pwdata = 8'h99;
      @(posedge pclk); #1;
      m_penable = 1'b1;
      @(negedge pclk);
      chk("abort.wait_low", 32'(o_pready), 32'd0);
      @(posedge pclk); #1;
      m_psel = 1'b0; m_penable = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
      chk("abort.pready_back", 32'(o_pready), 32'd1);
      xfer(1'b0, 8'h04, 8'h00, "abort.rd4");
      idle(1);

      // Reset asserted in the middle of a stalled write.
      @(posedge pclk); #1;
      m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1; m_paddr = 8'h05; m_pwdata = 8'hEE;
      @(posedge pclk); #1;
      m_penable = 1'b1;
      @(negedge pclk);
      chk("rstmid.wait_low", 32'(o_pready), 32'd0);
      #1 prstn = 1'b0;
      #1;
      chk("rstmid.pready_async", 32'(o_pready), 32'd1);
      clear_model();
      @(posedge pclk); #1;
      m_psel = 1'b0; m_penable = 1'b0;
      @(negedge pclk);
      prstn = 1'b1;
      xfer(1'b0, 8'h05, 8'h00, "rstmid.rd5");
      xfer(1'b0, 8'h06, 8'h00, "rstmid.rd6");
      idle(1);
      sel = 0;
      xfer(1'b0, 8'h02, 8'h00, "rstmid.dut0_rd2");
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer holding a small byte-wide register file, with a programmable number of wait states and error signalling for unmapped addresses. It sits directly downstream of the team's APB requester on the same pclk domain. It consumes psel/penable/paddr/pwrite/pwdata and returns pready/prdata/pslverr. pready idles high, so the requester can launch a transfer in any cycle.

## Interface
- DEPTH, 16: number of 8-bit registers at addresses 0..DEPTH-1; legal range 1..255.
- WAIT_CYCLES, 1: pready-low cycles inserted per access; legal range 0..7.
- ID_VALUE, 8'hA5: constant returned by reads of address 8'hFF.
- pclk  input  1  clock; all state changes on its rising edge.
- prstn  input  1  asynchronous active-low reset.
- psel  input  1  slave select.
- penable  input  1  access phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  8  byte address.
- pwdata  input  8  write data.
- prdata  output  8  read data.
- pready  output  1  transfer completion (registered).
- pslverr  output  1  error response for the completing transfer.

## Operation
- Address map:
  - 0..DEPTH-1: read/write registers.
  - 8'hFF: read-only ID register; writes are ignored without error.
  - Every other address is unmapped.
- State machine states: S_IDLE, S_WAIT, S_DONE.
- S_IDLE:
  - pready=1.
  - On an edge sampling psel=1 and penable=0 (setup phase), load cnt=WAIT_CYCLES.
  - Go to S_WAIT if WAIT_CYCLES>0, else S_DONE.
- S_WAIT:
  - pready=0; cnt decrements each edge.
  - When an edge samples cnt==1, go to S_DONE.
  - If psel is sampled 0 (protocol abort), go to S_IDLE with no register update.
- S_DONE:
  - pready=1; this cycle is the completion cycle (psel=1, penable=1).
  - At the ending edge, go to S_IDLE.
  - If that edge also samples a new setup phase (psel=1, penable=0), reload cnt and branch as from S_IDLE.
- Write commit:
  - At the completion edge (psel & penable & pready & pwrite sampled), mem[paddr] <= pwdata, only if paddr<DEPTH.
- Read data (combinational):
  - prdata = mem[paddr] when psel & penable & !pwrite & paddr<DEPTH.
  - prdata = ID_VALUE when psel & penable & !pwrite & paddr==8'hFF.
  - Otherwise prdata = 8'h00.
- pslverr (combinational): psel & penable & pready & unmapped address. Reads and writes alike.
- An unmapped write does not modify any register.
- cnt is 3 bits wide and never underflows (decrement only in S_WAIT, where cnt≥1).

## Timing
- Reset values: pready=1, pslverr=0, prdata=8'h00, state S_IDLE, cnt=0, all registers 8'h00.
- Reset is asynchronous. Asserting prstn low mid-transfer aborts the transfer immediately; no partial write occurs.
- Transfer latency, counted from the setup cycle:
  - WAIT_CYCLES=N gives 1 setup cycle + N access cycles with pready=0 + 1 access cycle with pready=1.
  - Total N+2 cycles.
- N=0: completion in the first access cycle (zero-wait APB).
- Back-to-back transfers (access followed directly by setup): no idle cycle is required. Wait insertion is identical for every transfer.
- A write is visible to a read whose access phase starts at or after the edge following the write's completion.
- pready changes only on pclk edges. prdata and pslverr are valid only while pready=1 in the access phase.

## Test plan
- Reset, then idle: pready=1, pslverr=0, prdata=8'h00. A read of addr 3 returns 8'h00.
- WAIT_CYCLES=1: write 8'h5C to addr 8'h02 with 3-cycle timing (pready low exactly 1 cycle). Then read addr 2 → prdata=8'h5C in the completion cycle, pslverr=0.
- WAIT_CYCLES=0: back-to-back writes of 8'h11→addr 0 and 8'h22→addr 15, then reads of both. Each transfer takes 2 cycles; the reads return 8'h11 and 8'h22.
- Unmapped address:
  - Write 8'h77 to addr 8'h10 (DEPTH=16) → pslverr=1 in the completion cycle; a subsequent read of addr 0 is unchanged.
  - Read addr 8'h80 → prdata=8'h00, pslverr=1.
- ID register: read addr 8'hFF → 8'hA5, pslverr=0. Writing 8'h00 there leaves the read value at 8'hA5, with no error.
- Abort and reset:
  - WAIT_CYCLES=3, write 8'h99 to addr 4, psel dropped after 1 wait cycle → addr 4 still 8'h00, pready=1 on the next cycle.
  - Separately, assert prstn low mid-wait → pready=1 immediately and all registers 8'h00.
